// File: rtl/ddr3_arb_pkg.sv
// Shared types for the DDR3 burst arbiter: FSM state encoding and command-length width.
package ddr3_arb_pkg;

    localparam int CMD_LEN_W = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_CMD  = 3'd1,
        WR_DATA = 3'd2,
        RD_CMD  = 3'd3,
        RD_DATA = 3'd4
    } arb_state_t;

endpackage

// File: rtl/burst_addr_gen.sv
// Per-channel burst address: steps by BURST_LEN per accepted command, wraps per frame.
// Frame-start is held pending and only takes effect while the arbiter is idle.
module burst_addr_gen #(
    parameter int unsigned ADDR_WIDTH  = 28,
    parameter int unsigned BASE        = 0,
    parameter int unsigned BURST_LEN   = 64,
    parameter int unsigned FRAME_BEATS = 129600
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_start,
    input  logic                  apply,
    input  logic                  advance,
    output logic [ADDR_WIDTH-1:0] addr
);

    localparam logic [ADDR_WIDTH-1:0] BASE_A = ADDR_WIDTH'(BASE);
    localparam logic [ADDR_WIDTH-1:0] WRAP_A = ADDR_WIDTH'(BASE + FRAME_BEATS);
    localparam logic [ADDR_WIDTH-1:0] STEP_A = ADDR_WIDTH'(BURST_LEN);

    logic                  pending;
    logic [ADDR_WIDTH-1:0] next_addr;

    assign next_addr = addr + STEP_A;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr    <= BASE_A;
            pending <= 1'b0;
        end else if (apply) begin
            // A pulse arriving in the idle cycle itself counts as pending.
            if (pending || frame_start) begin
                addr <= BASE_A;
            end
            pending <= 1'b0;
        end else begin
            if (frame_start) begin
                pending <= 1'b1;
            end
            if (advance) begin
                addr <= (next_addr == WRAP_A) ? BASE_A : next_addr;
            end
        end
    end

endmodule

// File: rtl/ddr3_burst_arbiter.sv
// Picks camera-write or HDMI-read DDR3 bursts and strobes the FIFO enables for their beats.
// Latency: one cycle from idle decision to cmd_valid; FIFO enables are combinational.
// Backpressure: cmd_ready holds the command; wdata_ready/rdata_valid gate beats.
module ddr3_burst_arbiter
    import ddr3_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = 28,
    parameter int unsigned LEVEL_WIDTH   = 10,
    parameter int unsigned BURST_LEN     = 64,
    parameter int unsigned RD_FIFO_DEPTH = 256,
    parameter int unsigned RD_URGENT     = 64,
    parameter int unsigned FRAME_BEATS   = 129600,
    parameter int unsigned WR_BASE       = 0,
    parameter int unsigned RD_BASE       = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LEVEL_WIDTH-1:0] wr_fifo_level,
    input  logic                   wr_frame_start,
    input  logic [LEVEL_WIDTH-1:0] rd_fifo_level,
    input  logic                   rd_frame_start,
    output logic                   cmd_valid,
    input  logic                   cmd_ready,
    output logic                   cmd_write,
    output logic [ADDR_WIDTH-1:0]  cmd_addr,
    output logic [CMD_LEN_W-1:0]   cmd_len,
    input  logic                   wdata_ready,
    output logic                   wr_fifo_rd_en,
    output logic                   wdata_last,
    input  logic                   rdata_valid,
    output logic                   rd_fifo_wr_en,
    output logic                   busy
);

    arb_state_t            state_q, state_d;
    logic [7:0]            cnt_q;
    logic                  last_write_q;
    logic                  wr_elig, rd_elig, rd_urgent, last_beat;
    logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;

    assign wr_elig   = 32'(wr_fifo_level) >= BURST_LEN;
    assign rd_elig   = (32'(rd_fifo_level) + BURST_LEN) <= RD_FIFO_DEPTH;
    assign rd_urgent = 32'(rd_fifo_level) < RD_URGENT;
    assign last_beat = cnt_q == 8'(BURST_LEN - 1);

    assign cmd_valid = (state_q == WR_CMD) || (state_q == RD_CMD);
    assign cmd_write = state_q == WR_CMD;
    assign cmd_len   = CMD_LEN_W'(BURST_LEN - 1);
    assign busy      = state_q != IDLE;
    assign cmd_addr  = (state_q == WR_CMD) ? wr_addr :
                       (state_q == RD_CMD) ? rd_addr : '0;

    always_comb begin
        state_d       = state_q;
        wr_fifo_rd_en = 1'b0;
        wdata_last    = 1'b0;
        rd_fifo_wr_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_elig && rd_elig) begin
                    state_d = (rd_urgent || last_write_q) ? RD_CMD : WR_CMD;
                end else if (wr_elig) begin
                    state_d = WR_CMD;
                end else if (rd_elig) begin
                    state_d = RD_CMD;
                end
            end
            WR_CMD:  if (cmd_ready) state_d = WR_DATA;
            RD_CMD:  if (cmd_ready) state_d = RD_DATA;
            WR_DATA: begin
                // Gated by rst so an abort suppresses the beat in the reset cycle too.
                wr_fifo_rd_en = wdata_ready && !rst;
                wdata_last    = wr_fifo_rd_en && last_beat;
                if (wdata_ready && last_beat) state_d = IDLE;
            end
            RD_DATA: begin
                rd_fifo_wr_en = rdata_valid && !rst;
                if (rdata_valid && last_beat) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_write_q <= 1'b1;
        end else begin
            state_q <= state_d;
            if (cmd_valid) begin
                cnt_q <= '0;
            end else if (wr_fifo_rd_en || rd_fifo_wr_en) begin
                cnt_q <= cnt_q + 8'd1;
            end
            if (cmd_valid && cmd_ready) begin
                last_write_q <= cmd_write;
            end
        end
    end

    burst_addr_gen #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .BASE        (WR_BASE),
        .BURST_LEN   (BURST_LEN),
        .FRAME_BEATS (FRAME_BEATS)
    ) u_wr_addr (
        .clk         (clk),
        .rst         (rst),
        .frame_start (wr_frame_start),
        .apply       (state_q == IDLE),
        .advance     ((state_q == WR_CMD) && cmd_ready),
        .addr        (wr_addr)
    );

    burst_addr_gen #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .BASE        (RD_BASE),
        .BURST_LEN   (BURST_LEN),
        .FRAME_BEATS (FRAME_BEATS)
    ) u_rd_addr (
        .clk         (clk),
        .rst         (rst),
        .frame_start (rd_frame_start),
        .apply       (state_q == IDLE),
        .advance     ((state_q == RD_CMD) && cmd_ready),
        .addr        (rd_addr)
    );

endmodule

// File: tb/tb_ddr3_burst_arbiter.sv
// Directed bench for ddr3_burst_arbiter with a 192-beat frame so address wrap is reachable.
module tb_ddr3_burst_arbiter;

    localparam int AW = 28;
    localparam int LW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic [LW-1:0] wr_fifo_level, rd_fifo_level;
    logic          wr_frame_start, rd_frame_start;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [7:0]    cmd_len;
    logic          wdata_ready, wr_fifo_rd_en, wdata_last;
    logic          rdata_valid, rd_fifo_wr_en, busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ddr3_burst_arbiter #(
        .ADDR_WIDTH    (AW),
        .LEVEL_WIDTH   (LW),
        .BURST_LEN     (64),
        .RD_FIFO_DEPTH (256),
        .RD_URGENT     (64),
        .FRAME_BEATS   (192),
        .WR_BASE       (0),
        .RD_BASE       (0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .wr_fifo_level  (wr_fifo_level),
        .wr_frame_start (wr_frame_start),
        .rd_fifo_level  (rd_fifo_level),
        .rd_frame_start (rd_frame_start),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_write      (cmd_write),
        .cmd_addr       (cmd_addr),
        .cmd_len        (cmd_len),
        .wdata_ready    (wdata_ready),
        .wr_fifo_rd_en  (wr_fifo_rd_en),
        .wdata_last     (wdata_last),
        .rdata_valid    (rdata_valid),
        .rd_fifo_wr_en  (rd_fifo_wr_en),
        .busy           (busy)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Entered in an idle cycle with levels already set; ends one cycle after acceptance.
    task automatic cmd_phase(input bit is_wr, input int exp_addr, input int ready_delay);
        int lat = 0;
        while (!cmd_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("cmd_latency", 32'(lat), 32'd1);
        chk("cmd_write", 32'(cmd_write), 32'(is_wr));
        chk("cmd_addr", 32'(cmd_addr), 32'(exp_addr));
        chk("cmd_len", 32'(cmd_len), 32'd63);
        for (int i = 0; i < ready_delay; i++) begin
            tick();
            chk("hold_valid", 32'(cmd_valid), 32'd1);
            chk("hold_addr", 32'(cmd_addr), 32'(exp_addr));
            chk("hold_write", 32'(cmd_write), 32'(is_wr));
        end
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
    endtask

    task automatic data_phase(input bit is_wr, input bit stall, input int fs_beat);
        int   beats = 0;
        int   pops  = 0;
        int   cyc   = 0;
        logic drive;
        while (beats < 64 && cyc < 1000) begin
            drive = stall ? logic'(cyc % 2 == 0) : 1'b1;
            if (is_wr) wdata_ready = drive;
            else       rdata_valid = drive;
            wr_frame_start = logic'(beats == fs_beat);
            #1;
            if (is_wr) begin
                chk("wr_en", 32'(wr_fifo_rd_en), 32'(drive));
                chk("wdata_last", 32'(wdata_last), 32'(drive && beats == 63));
                chk("rd_en_in_wr", 32'(rd_fifo_wr_en), 32'd0);
                if (wr_fifo_rd_en) pops++;
            end else begin
                chk("rd_en", 32'(rd_fifo_wr_en), 32'(drive));
                chk("wr_en_in_rd", 32'(wr_fifo_rd_en), 32'd0);
                if (rd_fifo_wr_en) pops++;
            end
            if (drive) beats++;
            tick();
            cyc++;
            wr_frame_start = 1'b0;
        end
        chk("beats_done", 32'(beats), 32'd64);
        chk("pops", 32'(pops), 32'd64);
        chk("busy_end", 32'(busy), 32'd0);
        wdata_ready = is_wr;
        rdata_valid = !is_wr;
        #1;
        chk("no_extra_en", 32'(wr_fifo_rd_en | rd_fifo_wr_en), 32'd0);
        wdata_ready = 1'b0;
        rdata_valid = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        wr_fifo_level  = '0;
        rd_fifo_level  = 10'd256;
        wr_frame_start = 1'b0;
        rd_frame_start = 1'b0;
        cmd_ready      = 1'b0;
        wdata_ready    = 1'b0;
        rdata_valid    = 1'b0;
        repeat (3) tick();

        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("rst_cmd_write", 32'(cmd_write), 32'd0);
        chk("rst_cmd_addr", 32'(cmd_addr), 32'd0);
        chk("rst_cmd_len", 32'(cmd_len), 32'd63);
        chk("rst_en", 32'(wr_fifo_rd_en | rd_fifo_wr_en | wdata_last), 32'd0);

        // Nothing eligible: stays idle.
        rst = 1'b0;
        repeat (3) tick();
        chk("idle_busy", 32'(busy), 32'd0);

        // Write-only traffic.
        wr_fifo_level = 10'd64;
        cmd_phase(1'b1, 0, 0);
        data_phase(1'b1, 1'b0, -1);
        cmd_phase(1'b1, 64, 0);
        data_phase(1'b1, 1'b0, -1);

        // Both eligible, not urgent: round robin starting with read.
        wr_fifo_level = 10'd128;
        rd_fifo_level = 10'd100;
        cmd_phase(1'b0, 0, 0);
        data_phase(1'b0, 1'b0, -1);
        cmd_phase(1'b1, 128, 0);
        data_phase(1'b1, 1'b0, -1);
        cmd_phase(1'b0, 64, 0);
        data_phase(1'b0, 1'b0, -1);

        // Urgent read wins although read was served last.
        rd_fifo_level = 10'd10;
        cmd_phase(1'b0, 128, 0);
        data_phase(1'b0, 1'b0, -1);

        // Write wraps to base; command stalled 5 cycles, data 50% ready.
        rd_fifo_level = 10'd100;
        cmd_phase(1'b1, 0, 5);
        data_phase(1'b1, 1'b1, -1);

        // Frame start mid-burst: burst completes, next write back at base.
        wr_fifo_level = 10'd64;
        rd_fifo_level = 10'd256;
        cmd_phase(1'b1, 64, 0);
        data_phase(1'b1, 1'b0, 10);
        cmd_phase(1'b1, 0, 0);
        data_phase(1'b1, 1'b0, -1);

        // Read-only traffic, then abort the second burst with reset.
        wr_fifo_level = 10'd0;
        rd_fifo_level = 10'd0;
        cmd_phase(1'b0, 0, 0);
        data_phase(1'b0, 1'b0, -1);
        cmd_phase(1'b0, 64, 0);
        for (int i = 0; i < 20; i++) begin
            rdata_valid = 1'b1;
            #1;
            chk("abort_pre_en", 32'(rd_fifo_wr_en), 32'd1);
            tick();
        end
        rst = 1'b1;
        #1;
        chk("abort_rst_gate", 32'(rd_fifo_wr_en), 32'd0);
        tick();
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_rd_en", 32'(rd_fifo_wr_en), 32'd0);
        chk("abort_cmd_valid", 32'(cmd_valid), 32'd0);

        // After reset both addresses restart at base and the first tie goes to read.
        rst           = 1'b0;
        rdata_valid   = 1'b0;
        wr_fifo_level = 10'd128;
        rd_fifo_level = 10'd100;
        cmd_phase(1'b0, 0, 0);
        data_phase(1'b0, 1'b0, -1);
        cmd_phase(1'b1, 0, 0);
        data_phase(1'b1, 1'b0, -1);

        wr_fifo_level = 10'd0;
        rd_fifo_level = 10'd256;
        repeat (2) tick();
        chk("final_busy", 32'(busy), 32'd0);
        chk("final_cmd_valid", 32'(cmd_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
